siggen_burst_trigger: RTL
=========================

Name: siggen_burst_trigger

Overview:
- Multi-channel, parametrised successor to the single-channel siggen trigger generator; sits between the register bank and the signal-generator trigger inputs.
- Each channel emits a programmable burst of trigger pulses: start delay, half-period, pulse count (0 = continuous) and mode (square or strobe).
- A register-bank start/stop bit launches or aborts all enabled channels together.
- Busy and done flags are returned to the register bank.

Parameters:
- NCH, 4, number of independent trigger channels.
- CNT_W, 32, width of half-period and delay counters.
- PCNT_W, 16, width of pulse-count field and pulse counter.

Ports:
- clki  in  1  system clock (100 MHz).
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  launch request; level from register bank; rising edge acts.
- stop  in  1  abort request; level from register bank; rising edge acts.
- ch_en  in  NCH  channel enable mask, latched at start.
- half_period  in  NCH*CNT_W  per-channel half-period H in clki cycles; channel i uses bits [i*CNT_W +: CNT_W].
- delay  in  NCH*CNT_W  per-channel start delay D in cycles.
- pulse_count  in  NCH*PCNT_W  per-channel pulse count N; 0 = continuous.
- mode  in  NCH  per channel: 0 = square (H high, H low); 1 = strobe (1 high, 2H-1 low).
- trig_out  out  NCH  trigger outputs, registered.
- busy  out  NCH  channel is in DELAY/HIGH/LOW.
- done  out  NCH  one-cycle pulse when a burst completes normally.

Behaviour:
- Reset (reset_n low, async): all channels IDLE; trig_out=0, busy=0, done=0; sync/edge registers cleared; latched config cleared.
- start and stop each pass through a 2-FF synchroniser plus an edge register. Rising edge = previous sample 0, current sample 1.
- Latency: start is first sampled high at edge E0 and detected after E1. Channels leave IDLE at E2.
- At E2 each channel i with ch_en[i]=1 latches H_i, D_i, N_i and mode_i, clears its counters and enters DELAY (or HIGH if D=0). Channels with ch_en[i]=0 stay in or are forced to IDLE.
- H=0 is treated as H=1. In strobe mode with H=1 the waveform is 1 high, 1 low.
- Per-channel FSM:
  - IDLE: trig_out=0, busy=0.
  - DELAY: lasts exactly D cycles, then HIGH.
  - HIGH: trig_out=1 for H cycles (square) or 1 cycle (strobe), then LOW.
  - LOW: trig_out=0 for H cycles (square) or 2H-1 cycles (strobe). Pulse counter increments on LOW exit. If N≠0 and the counter reaches N: go to IDLE and pulse done for 1 cycle. Otherwise go to HIGH.
- Period is always 2H cycles. First rising edge of trig_out is at E2+D.
- busy=1 in DELAY/HIGH/LOW. busy falls in the same cycle that done is high.
- Continuous mode (N=0): the pulse counter wraps at 2^PCNT_W with no effect; the channel runs until stop or restart.
- Restart: a start edge while busy reloads config and re-enters DELAY/HIGH at E2. trig_out is forced 0 in the DELAY cycles; no done is issued for the aborted burst.
- Stop edge: at the corresponding E2, all channels go to IDLE and trig_out=0; no done.
- Stop and start edges detected in the same cycle: stop wins; channels go IDLE.
- Config inputs changing mid-burst have no effect until the next start.
- N=1, square mode, H=2, D=0: trig_out pattern after E2 is 1,1,0,0, then IDLE, with done in the cycle after the last 0.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Package siggen_pkg:
  - state enum (IDLE, DELAY, HIGH, LOW);
  - mode encodings MODE_SQUARE=0, MODE_STROBE=1;
  - default widths.
- Sub-module siggen_trig_chan holds the per-channel FSM, counters and config latch. It is instantiated NCH times via generate.
- The top level holds the synchronisers and edge detection, and fans out start/stop pulses.

Test Plan:
- Reset: hold reset_n=0 mid-burst -> trig_out, busy and done all 0 immediately, without waiting for a clock edge.
- Ch0: H=3, D=5, N=2, square, start edge -> trig_out high at E2+5 for 3 cycles, low 3, high 3, low 3; done at E2+17; busy high E2..E2+16.
- Ch1: H=4, N=3, strobe, D=0 -> 1-cycle pulses at E2, E2+8, E2+16; done at E2+24.
- Ch2: N=0, H=1, then stop edge after 50 cycles -> toggles every cycle until stop E2, then 0; done never asserted.
- Ch0 running N=10, new start edge at pulse 4 with D=2 -> pulse restarts at new E2+2 and 10 full pulses follow; exactly one done.
- start and stop rising on the same clki edge with ch_en=4'b1111 -> all channels stay IDLE and trig_out=0; a start edge alone afterwards runs correctly.

Source files
------------

// File: rtl/siggen_pkg.sv
// -----------------------------------------------------------------------------
// siggen_pkg
// Shared types and default sizes for the burst trigger generator.
//   chan_state_e : per-channel FSM state (IDLE, DELAY, HIGH, LOW)
//   mode_e       : waveform shape (square = H high / H low,
//                  strobe = 1 high / 2H-1 low)
//   DEF_*        : default parameter values used by the interface and modules
// -----------------------------------------------------------------------------
package siggen_pkg;

    localparam int DEF_NCH    = 4;
    localparam int DEF_CNT_W  = 32;
    localparam int DEF_PCNT_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        HIGH  = 2'd2,
        LOW   = 2'd3
    } chan_state_e;

    typedef enum logic {
        MODE_SQUARE = 1'b0,
        MODE_STROBE = 1'b1
    } mode_e;

endpackage

// File: rtl/siggen_burst_trigger_if.sv
// -----------------------------------------------------------------------------
// siggen_burst_trigger_if
// Register-bank side of the burst trigger generator.
//   start, stop  : launch / abort levels (rising edge acts)
//   ch_en        : channel enable mask, sampled at launch
//   half_period  : per-channel H, channel i at [i*CNT_W +: CNT_W]
//   delay        : per-channel start delay D
//   pulse_count  : per-channel pulse count N (0 = continuous)
//   mode         : per-channel waveform mode (see siggen_pkg::mode_e)
//   busy, done   : per-channel status back to the register bank
// master = register bank, slave = trigger generator.
// -----------------------------------------------------------------------------
interface siggen_burst_trigger_if
    import siggen_pkg::*;
#(
    parameter int NCH    = DEF_NCH,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int PCNT_W = DEF_PCNT_W
) ();

    logic                    start;
    logic                    stop;
    logic [NCH-1:0]          ch_en;
    logic [NCH*CNT_W-1:0]    half_period;
    logic [NCH*CNT_W-1:0]    delay;
    logic [NCH*PCNT_W-1:0]   pulse_count;
    logic [NCH-1:0]          mode;
    logic [NCH-1:0]          busy;
    logic [NCH-1:0]          done;

    modport master (
        output start, stop, ch_en, half_period, delay, pulse_count, mode,
        input  busy, done
    );

    modport slave (
        input  start, stop, ch_en, half_period, delay, pulse_count, mode,
        output busy, done
    );

endinterface

// File: rtl/siggen_trig_chan.sv
// -----------------------------------------------------------------------------
// siggen_trig_chan
// One trigger channel: config latch, cycle counter, pulse counter and FSM.
//   clki, reset_n : clock, async active-low reset
//   start_p       : one-cycle synchronised launch pulse (shared by all channels)
//   stop_p        : one-cycle synchronised abort pulse (wins over start_p)
//   en            : channel enable, only looked at together with start_p
//   h_in, d_in    : half-period and start delay, latched on launch
//   n_in, mode_in : pulse count (0 = continuous) and mode, latched on launch
//   trig_out      : registered trigger output
//   busy          : registered, high while in DELAY/HIGH/LOW
//   done          : registered one-cycle pulse after the last LOW of a burst
// -----------------------------------------------------------------------------
module siggen_trig_chan
    import siggen_pkg::*;
#(
    parameter int CNT_W  = DEF_CNT_W,
    parameter int PCNT_W = DEF_PCNT_W
) (
    input  logic              clki,
    input  logic              reset_n,
    input  logic              start_p,
    input  logic              stop_p,
    input  logic              en,
    input  logic [CNT_W-1:0]  h_in,
    input  logic [CNT_W-1:0]  d_in,
    input  logic [PCNT_W-1:0] n_in,
    input  logic              mode_in,
    output logic              trig_out,
    output logic              busy,
    output logic              done
);

    // The cycle counter is one bit wider than H so that 2H-2 (strobe LOW) fits.
    localparam logic [CNT_W:0] ONE = {{CNT_W{1'b0}}, 1'b1};
    localparam logic [CNT_W:0] TWO = {{(CNT_W-1){1'b0}}, 2'b10};

    chan_state_e       state, state_nxt;
    logic [CNT_W:0]    cnt, cnt_nxt;
    logic [PCNT_W-1:0] pcnt, pcnt_nxt;
    logic              done_nxt;
    logic              load;

    logic [CNT_W-1:0]  h_q, d_q;
    logic [PCNT_W-1:0] n_q;
    mode_e             mode_q;

    logic [CNT_W:0]    high_last, low_last, delay_last;

    // Terminal counts for each timed state (counter runs 0 .. last).
    assign delay_last = {1'b0, d_q} - ONE;
    assign high_last  = (mode_q == MODE_STROBE) ? '0 : {1'b0, h_q} - ONE;
    assign low_last   = (mode_q == MODE_STROBE) ? {h_q, 1'b0} - TWO
                                                : {1'b0, h_q} - ONE;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case leaves a variable unassigned and infers a latch.
        state_nxt = state;
        cnt_nxt   = cnt;
        pcnt_nxt  = pcnt;
        done_nxt  = 1'b0;
        load      = 1'b0;

        if (stop_p) begin
            state_nxt = IDLE;
        end else if (start_p) begin
            // Launch or restart; an aborted burst never reports done.
            if (en) begin
                load      = 1'b1;
                cnt_nxt   = '0;
                pcnt_nxt  = '0;
                state_nxt = (d_in == '0) ? HIGH : DELAY;
            end else begin
                state_nxt = IDLE;
            end
        end else begin
            unique case (state)
                DELAY: begin
                    if (cnt == delay_last) begin
                        state_nxt = HIGH;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + ONE;
                    end
                end
                HIGH: begin
                    if (cnt == high_last) begin
                        state_nxt = LOW;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + ONE;
                    end
                end
                LOW: begin
                    if (cnt == low_last) begin
                        cnt_nxt  = '0;
                        // In continuous mode the pulse counter just wraps.
                        pcnt_nxt = pcnt + 1'b1;
                        if (n_q != '0 && pcnt_nxt == n_q) begin
                            state_nxt = IDLE;
                            done_nxt  = 1'b1;
                        end else begin
                            state_nxt = HIGH;
                        end
                    end else begin
                        cnt_nxt = cnt + ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clki or negedge reset_n) begin
        // NOTE: the latched config is cleared on reset as well; it is a handful
        // of flops, not a memory, and clearing it keeps reset state fully known.
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            pcnt     <= '0;
            h_q      <= '0;
            d_q      <= '0;
            n_q      <= '0;
            mode_q   <= MODE_SQUARE;
            trig_out <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every flop samples
            // the pre-edge values regardless of statement order.
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            pcnt     <= pcnt_nxt;
            // Outputs are decoded from the next state so they line up with
            // the state register while staying registered.
            trig_out <= (state_nxt == HIGH);
            busy     <= (state_nxt != IDLE);
            done     <= done_nxt;
            if (load) begin
                // H = 0 behaves as H = 1.
                h_q    <= h_in | {{(CNT_W-1){1'b0}}, (h_in == '0)};
                d_q    <= d_in;
                n_q    <= n_in;
                mode_q <= mode_e'(mode_in);
            end
        end
    end

endmodule

// File: rtl/siggen_burst_trigger.sv
// -----------------------------------------------------------------------------
// siggen_burst_trigger
// Multi-channel burst trigger generator between the register bank and the
// signal-generator trigger inputs.
//   clki, reset_n : 100 MHz clock, async active-low reset
//   bus (slave)   : register-bank controls and busy/done status
//   trig_out      : NCH registered trigger outputs
// start/stop go through a 2-FF synchroniser plus an edge register; the
// resulting one-cycle pulses are fanned out to every channel, which act on
// them two edges after the level is first sampled.
// -----------------------------------------------------------------------------
module siggen_burst_trigger
    import siggen_pkg::*;
#(
    parameter int NCH    = DEF_NCH,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int PCNT_W = DEF_PCNT_W
) (
    input  logic                    clki,
    input  logic                    reset_n,
    siggen_burst_trigger_if.slave   bus,
    output logic [NCH-1:0]          trig_out
);

    // [0],[1] synchroniser stages, [2] previous sample for edge detection.
    logic [2:0]     start_sync, stop_sync;
    logic           start_p, stop_p;
    logic [NCH-1:0] busy_v, done_v;

    always_ff @(posedge clki or negedge reset_n) begin
        if (!reset_n) begin
            start_sync <= '0;
            stop_sync  <= '0;
        end else begin
            start_sync <= {start_sync[1:0], bus.start};
            stop_sync  <= {stop_sync[1:0], bus.stop};
        end
    end

    assign start_p = start_sync[1] & ~start_sync[2];
    assign stop_p  = stop_sync[1]  & ~stop_sync[2];

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        siggen_trig_chan #(
            .CNT_W  (CNT_W),
            .PCNT_W (PCNT_W)
        ) u_chan (
            .clki     (clki),
            .reset_n  (reset_n),
            .start_p  (start_p),
            .stop_p   (stop_p),
            .en       (bus.ch_en[i]),
            .h_in     (bus.half_period[i*CNT_W +: CNT_W]),
            .d_in     (bus.delay[i*CNT_W +: CNT_W]),
            .n_in     (bus.pulse_count[i*PCNT_W +: PCNT_W]),
            .mode_in  (bus.mode[i]),
            .trig_out (trig_out[i]),
            .busy     (busy_v[i]),
            .done     (done_v[i])
        );
    end

    assign bus.busy = busy_v;
    assign bus.done = done_v;

endmodule
